abc_stimulus_sequencer: RTL and testbench

Upstream stimulus and capture stage for the three-input boolean function block (F = !ABC + A!BC + AB!C, true when exactly two inputs are high). On a start pulse it steps {A,B,C} through all eight combinations and holds each vector for a programmable settle time. At the end of each hold it samples F and assembles the 8-bit observed truth table, then compares it against an expected constant. Used for on-board self-check of the lab's combinational block and for exhaustive bench stimulus.

---
 rtl/abc_stimulus_sequencer_if.sv | 36 +++
 rtl/abc_stimulus_sequencer.sv | 152 +++++++++++++++
 tb/tb_abc_stimulus_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/abc_stimulus_sequencer_if.sv
// Stimulus/capture bundle between the sweep sequencer and the function block under test.
interface abc_stimulus_sequencer_if;
    logic       i_start;
    logic       i_F;
    logic       o_A;
    logic       o_B;
    logic       o_C;
    logic       o_busy;
    logic       o_done;
    logic       o_pass;
    logic [7:0] o_table;

    modport slave (
        input  i_start,
        input  i_F,
        output o_A,
        output o_B,
        output o_C,
        output o_busy,
        output o_done,
        output o_pass,
        output o_table
    );

    modport master (
        output i_start,
        output i_F,
        input  o_A,
        input  o_B,
        input  o_C,
        input  o_busy,
        input  o_done,
        input  o_pass,
        input  o_table
    );
endinterface

// File: rtl/abc_stimulus_sequencer.sv
// Exhaustive {A,B,C} sweep with per-vector settle hold, F capture and truth-table compare.
// Optional ABC_F_SYNC_EN: two-flop synchronizer on i_F, hold stretched by two cycles.
module abc_stimulus_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  EXPECTED      = 8'h68
) (
    input logic                     i_clk,
    input logic                     i_rst_n,
    abc_stimulus_sequencer_if.slave bus
);

`ifdef ABC_F_SYNC_EN
    localparam int unsigned SyncLat = 2;
`else
    localparam int unsigned SyncLat = 0;
`endif
    localparam int unsigned HoldCycles = SETTLE_CYCLES + SyncLat;
    // A 257-cycle hold (255 + synchronizer) needs one extra counter bit.
    localparam int unsigned CntW = (HoldCycles > 256) ? 9 : 8;
    localparam logic [CntW-1:0] Reload = CntW'(HoldCycles - 1);

    typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      tbl_q, tbl_d;
    logic            pass_q, pass_d;

    logic            f_smp;
    logic            sample_now;
    logic            start_ok;
    logic            busy;
    logic            done;
    logic [2:0]      abc;

`ifdef ABC_F_SYNC_EN
    logic [1:0] f_sync_q, f_sync_d;

    always_comb begin
        f_sync_d = {f_sync_q[0], bus.i_F};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            f_sync_q <= 2'b00;
        end else begin
            f_sync_q <= f_sync_d;
        end
    end

    assign f_smp = f_sync_q[1];
`else
    assign f_smp = bus.i_F;
`endif

    assign sample_now = (state_q == StDrive) && (cnt_q == '0);
    // Starts arriving mid-sweep are dropped so the sweep is never restarted or extended.
    assign start_ok   = bus.i_start && (state_q != StDrive);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    state_d = StDrive;
                end
            end
            StDrive: begin
                if (sample_now && (idx_q == 3'd7)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.i_start) begin
                    state_d = StDrive;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        abc  = 3'b000;
        case (state_q)
            StDrive: begin
                busy = 1'b1;
                abc  = idx_q;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        tbl_d  = tbl_q;
        pass_d = pass_q;
        if (start_ok) begin
            idx_d  = 3'd0;
            cnt_d  = Reload;
            tbl_d  = 8'h00;
            pass_d = 1'b0;
        end else if (state_q == StDrive) begin
            if (cnt_q == '0) begin
                tbl_d[idx_q] = f_smp;
                if (idx_q == 3'd7) begin
                    pass_d = (tbl_d == EXPECTED);
                end else begin
                    idx_d = idx_q + 3'd1;
                    cnt_d = Reload;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_q  <= 3'd0;
            cnt_q  <= '0;
            tbl_q  <= 8'h00;
            pass_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            tbl_q  <= tbl_d;
            pass_q <= pass_d;
        end
    end

    assign bus.o_A     = abc[2];
    assign bus.o_B     = abc[1];
    assign bus.o_C     = abc[0];
    assign bus.o_busy  = busy;
    assign bus.o_done  = done;
    assign bus.o_pass  = pass_q;
    assign bus.o_table = tbl_q;

endmodule

// File: tb/tb_abc_stimulus_sequencer.sv
// Directed bench: three sequencers (settle 4, 1, 255) against a behavioural exactly-two model.
module tb_abc_stimulus_sequencer;

`ifdef ABC_F_SYNC_EN
    localparam int Extra = 2;
`else
    localparam int Extra = 0;
`endif
    localparam int H0 = 4 + Extra;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   mode  = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    abc_stimulus_sequencer_if bus0 ();
    abc_stimulus_sequencer_if bus1 ();
    abc_stimulus_sequencer_if bus2 ();

    function automatic logic exact2(input logic a, input logic b, input logic c);
        return (a & b & ~c) | (a & ~b & c) | (~a & b & c);
    endfunction

    function automatic logic model(input int m, input logic a, input logic b, input logic c);
        case (m)
            0:       return exact2(a, b, c);
            1:       return 1'b0;
            default: return ~exact2(a, b, c);
        endcase
    endfunction

    assign bus0.i_start = start;
    assign bus1.i_start = start;
    assign bus2.i_start = start;
    assign bus0.i_F = model(mode, bus0.o_A, bus0.o_B, bus0.o_C);
    assign bus1.i_F = exact2(bus1.o_A, bus1.o_B, bus1.o_C);
    assign bus2.i_F = exact2(bus2.o_A, bus2.o_B, bus2.o_C);

    abc_stimulus_sequencer #(.SETTLE_CYCLES(4), .EXPECTED(8'h68)) u_dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus0)
    );
    abc_stimulus_sequencer #(.SETTLE_CYCLES(1), .EXPECTED(8'h68)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );
    abc_stimulus_sequencer #(.SETTLE_CYCLES(255), .EXPECTED(8'h68)) u_dut2 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus2)
    );

    logic [2:0] abc0;
    logic       busy_w [3];
    logic       done_w [3];
    logic       pass_w [3];
    logic [7:0] tbl_w  [3];
    int         busy_cnt [3];

    assign abc0      = {bus0.o_A, bus0.o_B, bus0.o_C};
    assign busy_w[0] = bus0.o_busy;
    assign busy_w[1] = bus1.o_busy;
    assign busy_w[2] = bus2.o_busy;
    assign done_w[0] = bus0.o_done;
    assign done_w[1] = bus1.o_done;
    assign done_w[2] = bus2.o_done;
    assign pass_w[0] = bus0.o_pass;
    assign pass_w[1] = bus1.o_pass;
    assign pass_w[2] = bus2.o_pass;
    assign tbl_w[0]  = bus0.o_table;
    assign tbl_w[1]  = bus1.o_table;
    assign tbl_w[2]  = bus2.o_table;

    // Busy-cycle length of the most recent accepted sweep, per instance.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (start && !busy_w[i]) begin
                busy_cnt[i] <= 0;
            end else if (busy_w[i]) begin
                busy_cnt[i] <= busy_cnt[i] + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int n = 0;
        while (!done_w[i] && n < budget) begin
            tick();
            n++;
        end
        check_eq($sformatf("done_reached%0d", i), 32'(done_w[i]), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check_eq("rst_table", 32'(bus0.o_table), 32'h00);
        check_eq("rst_busy",  32'(bus0.o_busy),  32'd0);
        check_eq("rst_done",  32'(bus0.o_done),  32'd0);
        check_eq("rst_pass",  32'(bus0.o_pass),  32'd0);
        check_eq("rst_abc",   32'(abc0),         32'd0);
        #3 rst_n = 1'b1;
        repeat (2) tick();

        // Nominal sweep: vectors walk 0..7, each held H0 cycles.
        mode = 0;
        pulse_start();
        check_eq("start_busy", 32'(bus0.o_busy), 32'd1);
        for (int k = 0; k < 8 * H0; k++) begin
            check_eq($sformatf("walk_c%0d", k), 32'(abc0), 32'(k / H0));
            tick();
        end
        check_eq("sw_done",  32'(bus0.o_done),  32'd1);
        check_eq("sw_busy",  32'(bus0.o_busy),  32'd0);
        check_eq("sw_abc",   32'(abc0),         32'd0);
        check_eq("sw_table", 32'(bus0.o_table), 32'h68);
        check_eq("sw_pass",  32'(bus0.o_pass),  32'd1);
        check_eq("sw_len",   32'(busy_cnt[0]),  32'(8 * H0));

        wait_done(2, 2200);
        check_eq("s1_len",     32'(busy_cnt[1]), 32'(8 * (1 + Extra)));
        check_eq("s1_table",   32'(tbl_w[1]),    32'h68);
        check_eq("s1_pass",    32'(pass_w[1]),   32'd1);
        check_eq("s255_len",   32'(busy_cnt[2]), 32'(8 * (255 + Extra)));
        check_eq("s255_table", 32'(tbl_w[2]),    32'h68);
        check_eq("s255_pass",  32'(pass_w[2]),   32'd1);

        // F stuck low.
        mode = 1;
        pulse_start();
        wait_done(0, 100);
        check_eq("f0_table", 32'(bus0.o_table), 32'h00);
        check_eq("f0_pass",  32'(bus0.o_pass),  32'd0);
        check_eq("f0_len",   32'(busy_cnt[0]),  32'(8 * H0));

        // Starts during a sweep are ignored.
        mode = 0;
        pulse_start();
        repeat (4) tick();
        pulse_start();
        repeat (13) tick();
        pulse_start();
        wait_done(0, 100);
        check_eq("rs_len",   32'(busy_cnt[0]),  32'(8 * H0));
        check_eq("rs_table", 32'(bus0.o_table), 32'h68);
        check_eq("rs_pass",  32'(bus0.o_pass),  32'd1);

        // Restart from DONE with inverted F.
        mode = 2;
        pulse_start();
        check_eq("inv_done_drop", 32'(bus0.o_done),  32'd0);
        check_eq("inv_pass_drop", 32'(bus0.o_pass),  32'd0);
        check_eq("inv_busy",      32'(bus0.o_busy),  32'd1);
        check_eq("inv_tbl_clr",   32'(bus0.o_table), 32'h00);
        wait_done(0, 100);
        check_eq("inv_table", 32'(bus0.o_table), 32'h97);
        check_eq("inv_pass",  32'(bus0.o_pass),  32'd0);

        // Asynchronous reset in mid-sweep, with some table bits already captured.
        mode = 2;
        pulse_start();
        repeat (12) tick();
        check_eq("pre_rst_tbl_nz", 32'(bus0.o_table != 8'h00), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_busy",  32'(bus0.o_busy),  32'd0);
        check_eq("mrst_abc",   32'(abc0),         32'd0);
        check_eq("mrst_done",  32'(bus0.o_done),  32'd0);
        check_eq("mrst_pass",  32'(bus0.o_pass),  32'd0);
        check_eq("mrst_table", 32'(bus0.o_table), 32'h00);
        #2 rst_n = 1'b1;
        repeat (10) tick();
        check_eq("idle_busy",  32'(bus0.o_busy),  32'd0);
        check_eq("idle_done",  32'(bus0.o_done),  32'd0);
        check_eq("idle_abc",   32'(abc0),         32'd0);
        check_eq("idle_table", 32'(bus0.o_table), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
